id_ex_stage: RTL
================

# id_ex_stage

Pipeline register between decode and execute in the 5-stage MIPS core. It captures the control bundle from the opcode decoder together with decode-stage operands and register indices. It detects load-use hazards against the instruction currently in EX and requests a one-cycle stall. It inserts a bubble on stall or on a branch-taken flush.

## Interface
- `ZERO_REG`, default `5'd0`: architectural zero register index; never a hazard source.
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `id_valid` input, 1 bit: ID slot holds a real instruction.
- `id_pc` input, 32 bits: PC+4 of the ID instruction.
- `id_rs_data`, `id_rt_data` input, 32 bits each: register-file read data.
- `id_imm` input, 32 bits: sign-extended immediate.
- `id_rs`, `id_rt`, `id_rd` input, 5 bits each: register indices.
- `id_funct` input, 6 bits: R-type function field.
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`, `id_alusrc`, `id_branch`, `id_regdst` input, 1 bit each: decoder control.
- `id_aluop` input, 4 bits: decoder ALU op.
- `flush_i` input, 1 bit: branch taken in EX; kill the ID instruction.
- `stall_o` output, 1 bit: combinational; holds PC and IF/ID this cycle.
- `ex_valid` output, 1 bit: EX slot holds a real instruction.
- `ex_pc`, `ex_rs_data`, `ex_rt_data`, `ex_imm` output, 32 bits each: registered copies.
- `ex_rs`, `ex_rt` output, 5 bits each: registered indices, used for forwarding.
- `ex_dst` output, 5 bits: resolved destination; `id_rd` if `id_regdst`=1, else `id_rt`.
- `ex_funct` output, 6 bits; `ex_aluop` output, 4 bits.
- `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_memtoreg`, `ex_alusrc`, `ex_branch` output, 1 bit each.
- `bubble_cnt` output, 32 bits: load-use bubble count (see Configuration).

## Operation
- Hazard: `hz` = `id_valid` & `ex_valid` & `ex_memread` & (`ex_dst` != `ZERO_REG`) & ((`ex_dst` == `id_rs`) | ((`ex_dst` == `id_rt`) & `uses_rt`)).
- `uses_rt` = ~`id_alusrc` | `id_memwrite`. This covers R-type, SW and BEQ.
- `stall_o` = `hz` & ~`flush_i`.
- Each clock edge, one of the following applies, in priority order:
  - `flush_i`=1: load a bubble. `stall_o`=0. The ID instruction is discarded upstream.
  - `hz`=1: load a bubble. The ID instruction is held upstream and re-presented next cycle.
  - Otherwise: load all ID fields. `ex_valid` <= `id_valid`.
- Bubble: `ex_valid`=0 and every control output (including `ex_aluop`) = 0. Data and index fields still load their ID values, and their contents are don't-care.
- When `id_valid`=0, control outputs are also forced to 0 on load, so nothing invalid is ever committed.
- There is no pipeline hold from downstream: the EX slot advances every cycle.

## Timing
- Reset (asynchronous assert, synchronous deassert upstream): every `ex_*` output = 0, `ex_valid`=0, `bubble_cnt`=0.
- `stall_o` is high during reset only if the inputs demand it. Since `ex_valid`=0 under reset, it is 0.
- Latency: ID to EX is 1 cycle.
- A load-use pair costs exactly 1 bubble.
  - After the bubble, `ex_valid`=0, so `hz` drops.
  - The held instruction then loads normally, and forwarding from MEM covers it.
- Back-to-back loads, where the second depends on the first, also cost exactly 1 bubble.
- Simultaneous `flush_i` and `hz`: flush wins, `stall_o`=0, one bubble is loaded, and the counter does not increment.
- Reset asserted mid-stall: outputs clear immediately and `stall_o` drops combinationally.

## Configuration
- `ID_EX_BUBBLE_CNT_EN` defined:
  - `bubble_cnt` increments on each edge where `hz` & ~`flush_i`.
  - It saturates at 32'hFFFF_FFFF.
- `ID_EX_BUBBLE_CNT_EN` undefined:
  - No counter flops are present.
  - `bubble_cnt` is tied to 0.
  - The port list is unchanged.

## Structure
- Shared package/header `mips_pkg`:
  - opcode constants (RTYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000);
  - `aluop` encodings (0000 add, 0001 sub, 0010 funct-decode);
  - register-index width;
  - the control-bundle field list, shared with the decoder.
- Sub-module `hazard_detect`: purely combinational, computes `hz` from ID indices, `uses_rt` inputs, and EX `memread`/`dst`/`valid`.
- `id_ex_stage` holds the registers, priority mux, destination resolution and the optional counter.

## Test plan
- Reset with all inputs toggling: every output is 0 and `stall_o`=0 until the first valid load.
- Load-use: LW writing r8 in EX, then ADD reading r8 as rs in ID. Expect `stall_o`=1 for one cycle, then a bubble (`ex_valid`=0, controls 0), then the ADD loads. `bubble_cnt`=1.
- LW writing r8, then ADDI with rt=8 (`uses_rt`=0): no stall. LW writing r0, then ADD reading r0: no stall.
- LW writing r8 in EX, SW using rt=8 in ID, and `flush_i`=1 in the same cycle: `stall_o`=0, a bubble is loaded, and `bubble_cnt` is unchanged.
- R-type with rd=12, rt=5: `ex_dst`=12. LW with rt=5: `ex_dst`=5, `ex_memread`=1, `ex_memtoreg`=1.
- With the counter enabled and forced to 32'hFFFF_FFFE, trigger 3 hazards: `bubble_cnt` ends at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, ALU op encodings, register index width and the
// decoder control bundle.
package mips_pkg;

    localparam int unsigned RegW = 5;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [3:0] AluAdd   = 4'b0000;
    localparam logic [3:0] AluSub   = 4'b0001;
    localparam logic [3:0] AluFunct = 4'b0010;

    // Control fields that travel past decode into EX.
    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       branch;
        logic [3:0] aluop;
    } ex_ctrl_t;

    // Full decoder bundle; regdst is consumed in ID/EX to resolve the destination.
    typedef struct packed {
        ex_ctrl_t ex;
        logic     regdst;
    } ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection between the ID instruction and a load in EX.
module hazard_detect
    import mips_pkg::*;
#(
    parameter logic [RegW-1:0] ZERO_REG = 5'd0
) (
    input  logic            id_valid,
    input  logic [RegW-1:0] id_rs,
    input  logic [RegW-1:0] id_rt,
    input  logic            id_alusrc,
    input  logic            id_memwrite,
    input  logic            ex_valid,
    input  logic            ex_memread,
    input  logic [RegW-1:0] ex_dst,
    output logic            hz
);

    logic uses_rt;

    // R-type, SW and BEQ read rt as a source; ADDI/LW only write it.
    assign uses_rt = ~id_alusrc | id_memwrite;

    assign hz = id_valid & ex_valid & ex_memread & (ex_dst != ZERO_REG) &
                ((ex_dst == id_rs) | ((ex_dst == id_rt) & uses_rt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and flush bubble insertion.
// Optional saturating load-use bubble counter enabled by ID_EX_BUBBLE_CNT_EN.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter logic [RegW-1:0] ZERO_REG = 5'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [31:0]     id_pc,
    input  logic [31:0]     id_rs_data,
    input  logic [31:0]     id_rt_data,
    input  logic [31:0]     id_imm,
    input  logic [RegW-1:0] id_rs,
    input  logic [RegW-1:0] id_rt,
    input  logic [RegW-1:0] id_rd,
    input  logic [5:0]      id_funct,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            id_alusrc,
    input  logic            id_branch,
    input  logic            id_regdst,
    input  logic [3:0]      id_aluop,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            ex_valid,
    output logic [31:0]     ex_pc,
    output logic [31:0]     ex_rs_data,
    output logic [31:0]     ex_rt_data,
    output logic [31:0]     ex_imm,
    output logic [RegW-1:0] ex_rs,
    output logic [RegW-1:0] ex_rt,
    output logic [RegW-1:0] ex_dst,
    output logic [5:0]      ex_funct,
    output logic [3:0]      ex_aluop,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_memtoreg,
    output logic            ex_alusrc,
    output logic            ex_branch,
    output logic [31:0]     bubble_cnt
);

    ctrl_t           id_ctrl;
    ex_ctrl_t        ctrl_d, ctrl_q;
    logic            valid_d, valid_q;
    logic [RegW-1:0] dst_d, dst_q;
    logic [31:0]     pc_q, rs_data_q, rt_data_q, imm_q;
    logic [RegW-1:0] rs_q, rt_q;
    logic [5:0]      funct_q;
    logic            hz;

    assign id_ctrl = '{
        ex: '{
            regwrite: id_regwrite,
            memread:  id_memread,
            memwrite: id_memwrite,
            memtoreg: id_memtoreg,
            alusrc:   id_alusrc,
            branch:   id_branch,
            aluop:    id_aluop
        },
        regdst: id_regdst
    };

    hazard_detect #(
        .ZERO_REG (ZERO_REG)
    ) u_hazard_detect (
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_alusrc   (id_alusrc),
        .id_memwrite (id_memwrite),
        .ex_valid    (valid_q),
        .ex_memread  (ctrl_q.memread),
        .ex_dst      (dst_q),
        .hz          (hz)
    );

    assign stall_o = hz & ~flush_i;

    always_comb begin
        valid_d = id_valid & ~flush_i & ~hz;
        // Invalid or bubbled slots never carry live control.
        ctrl_d  = valid_d ? id_ctrl.ex : '0;
        dst_d   = id_ctrl.regdst ? id_rd : id_rt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            dst_q     <= '0;
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            funct_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            dst_q     <= dst_d;
            pc_q      <= id_pc;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            funct_q   <= id_funct;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (stall_o && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = '0;
`endif

    assign ex_valid    = valid_q;
    assign ex_pc       = pc_q;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_rs       = rs_q;
    assign ex_rt       = rt_q;
    assign ex_dst      = dst_q;
    assign ex_funct    = funct_q;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_memtoreg = ctrl_q.memtoreg;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_branch   = ctrl_q.branch;

endmodule
